// File: rtl/if_fetch_controller.sv
// IF-stage fetch sequencer: owns the fetch PC, runs the req/ready handshake to
// instruction memory, and feeds the IF pipeline register (load/flush/PC/instr).
module if_fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        if_load,
    output logic        if_flush,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        mem_err
);

    localparam int unsigned     CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [31:0]      req_addr_r, req_addr_nxt_s;
    logic [31:0]      hold_instr_r, hold_instr_nxt_s;
    logic             kill_r, kill_nxt_s;
    logic [31:0]      redirect_addr_r, redirect_nxt_s;
    logic [CNT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
    logic             mem_err_r, mem_err_nxt_s;
    logic             load_s;
    logic [31:0]      pc_s;
    logic [31:0]      instr_s;
    logic [31:0]      target_s;

    assign target_s = word_align(branch_target);

    // Next-state and IF-register drive; a response is consumed only when no redirect is pending
    always_comb begin
        state_nxt_s      = state_r;
        req_addr_nxt_s   = req_addr_r;
        hold_instr_nxt_s = hold_instr_r;
        kill_nxt_s       = kill_r;
        redirect_nxt_s   = redirect_addr_r;
        wait_cnt_nxt_s   = wait_cnt_r;
        mem_err_nxt_s    = mem_err_r;
        load_s           = 1'b0;
        pc_s             = 32'd0;
        instr_s          = 32'd0;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_REQ;
            end
            ST_REQ: begin
                if (mem_ready) begin
                    wait_cnt_nxt_s = CNT_ZERO;
                    if (branch_taken) begin
                        req_addr_nxt_s = target_s;
                        kill_nxt_s     = 1'b0;
                    end else if (kill_r) begin
                        req_addr_nxt_s = redirect_addr_r;
                        kill_nxt_s     = 1'b0;
                    end else if (stall_in) begin
                        hold_instr_nxt_s = mem_rdata;
                        state_nxt_s      = ST_HOLD;
                    end else begin
                        load_s         = 1'b1;
                        pc_s           = pc_inc(req_addr_r);
                        instr_s        = mem_rdata;
                        req_addr_nxt_s = pc_inc(req_addr_r);
                    end
                end else begin
                    // The request cannot be withdrawn, so a redirect is remembered until it lands
                    if (branch_taken) begin
                        kill_nxt_s     = 1'b1;
                        redirect_nxt_s = target_s;
                    end else begin
                        kill_nxt_s     = kill_r;
                    end
                    if (wait_cnt_r != CNT_MAX) begin
                        wait_cnt_nxt_s = wait_cnt_r + CNT_ONE;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r;
                    end
                    if (wait_cnt_nxt_s == CNT_MAX) begin
                        mem_err_nxt_s = 1'b1;
                    end else begin
                        mem_err_nxt_s = mem_err_r;
                    end
                end
            end
            ST_HOLD: begin
                pc_s    = pc_inc(req_addr_r);
                instr_s = hold_instr_r;
                if (branch_taken) begin
                    hold_instr_nxt_s = 32'd0;
                    req_addr_nxt_s   = target_s;
                    state_nxt_s      = ST_REQ;
                end else if (!stall_in) begin
                    load_s         = 1'b1;
                    req_addr_nxt_s = pc_inc(req_addr_r);
                    state_nxt_s    = ST_REQ;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r         <= ST_IDLE;
            req_addr_r      <= RESET_PC;
            hold_instr_r    <= 32'd0;
            kill_r          <= 1'b0;
            redirect_addr_r <= 32'd0;
            wait_cnt_r      <= CNT_ZERO;
            mem_err_r       <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            req_addr_r      <= req_addr_nxt_s;
            hold_instr_r    <= hold_instr_nxt_s;
            kill_r          <= kill_nxt_s;
            redirect_addr_r <= redirect_nxt_s;
            wait_cnt_r      <= wait_cnt_nxt_s;
            mem_err_r       <= mem_err_nxt_s;
        end
    end

    assign mem_req  = (state_r == ST_REQ);
    assign mem_addr = req_addr_r;
    assign if_load  = load_s;
    assign if_flush = branch_taken;
    assign if_pc    = pc_s;
    assign if_instr = instr_s;
    assign mem_err  = mem_err_r;

    if_fetch_controller_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .if_load   (if_load),
        .if_flush  (if_flush),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .mem_err   (mem_err),
        .in_hold   (state_r == ST_HOLD)
    );

endmodule

// Protocol invariants of the fetch controller's external interfaces.
module if_fetch_controller_chk (
    input logic        clk,
    input logic        rst,
    input logic        mem_req,
    input logic        mem_ready,
    input logic [31:0] mem_addr,
    input logic        if_load,
    input logic        if_flush,
    input logic [31:0] if_pc,
    input logic [31:0] if_instr,
    input logic        mem_err,
    input logic        in_hold
);

    a_req_held: assert property (@(posedge clk) disable iff (!rst)
        (mem_req && !mem_ready) |=> (mem_req && $stable(mem_addr)));

    a_load_flush_excl: assert property (@(posedge clk) disable iff (!rst)
        !(if_load && if_flush));

    a_err_sticky: assert property (@(posedge clk) disable iff (!rst)
        mem_err |=> mem_err);

    a_quiet_data: assert property (@(posedge clk) disable iff (!rst)
        (!if_load && !in_hold) |-> (if_pc == 32'd0 && if_instr == 32'd0));

endmodule

// File: doc/if_fetch_controller.md
Name: if_fetch_controller

Overview:
Sequences instruction fetch for the IF stage. Owns the fetch PC and drives a req/ready handshake to instruction memory with variable latency. Produces the load and flush strobes and the PC/instruction data for the IF stage pipeline register. Handles branch redirects arriving mid-transaction, and downstream stalls by buffering one fetched word.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
MAX_WAIT, 64, REQ cycles without mem_ready before mem_err is set (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
stall_in  in  1  hazard unit: hold the IF stage register this cycle
branch_taken  in  1  redirect request from the resolving stage (one-cycle pulse per branch)
branch_target  in  32  redirect address; valid when branch_taken=1
mem_req  out  1  fetch request to instruction memory
mem_addr  out  32  fetch address; word aligned
mem_ready  in  1  memory response strobe; mem_rdata valid this cycle
mem_rdata  in  32  fetched instruction
if_load  out  1  write-enable to the IF stage register
if_flush  out  1  flush to the IF stage register
if_pc  out  32  PC_in for the IF stage register (fetched address + 4)
if_instr  out  32  Instruction_in for the IF stage register
mem_err  out  1  sticky watchdog flag

Behaviour:
- Internal registers:
  - state {IDLE, REQ, HOLD}
  - req_addr (32)
  - hold_instr (32)
  - kill (1)
  - redirect_addr (32)
  - wait_cnt (ceil log2(MAX_WAIT+1) bits)
  - mem_err
- Reset (rst=0, asynchronous):
  - state=IDLE, req_addr=RESET_PC, kill=0, hold_instr=0, wait_cnt=0, mem_err=0.
  - All outputs 0 immediately; mem_req drops without waiting for a clock edge.
- mem_req = (state==REQ). mem_addr = req_addr.
- While mem_req=1 and mem_ready=0, mem_addr is held stable. A request is never withdrawn.
- if_flush = branch_taken (combinational, same cycle). Branch has priority over stall.
- IDLE: mem_req=0. Moves to REQ on the next edge (first request one cycle after reset release).
- REQ, mem_ready=0:
  - If branch_taken: kill<=1, redirect_addr<=branch_target. A later branch overwrites redirect_addr.
  - wait_cnt increments, saturating. When it reaches MAX_WAIT, mem_err<=1 until reset. Fetch continues regardless.
- REQ, mem_ready=1 (wait_cnt<=0 in every case):
  - If branch_taken: discard mem_rdata, if_load=0, req_addr<=branch_target, kill<=0, stay REQ.
  - Else if kill: discard mem_rdata, if_load=0, req_addr<=redirect_addr, kill<=0, stay REQ.
  - Else if stall_in: hold_instr<=mem_rdata, if_load=0, go HOLD.
  - Else: if_load=1, if_instr=mem_rdata, if_pc=req_addr+4. Then req_addr<=req_addr+4 and stay REQ. Back-to-back requests: mem_req stays high.
- HOLD: mem_req=0; if_instr=hold_instr, if_pc=req_addr+4.
  - If branch_taken: drop buffer, req_addr<=branch_target, go REQ.
  - Else if !stall_in: if_load=1, req_addr<=req_addr+4, go REQ.
  - Else: stay HOLD, if_load=0.
- if_load is never asserted in the same cycle as if_flush.
- if_pc/if_instr are 0 in any cycle where if_load=0 and state!=HOLD.
- Arithmetic: PC increment is modulo 2^32; 32'hFFFF_FFFC wraps to 0. branch_target[1:0] is forced to 00.
- Latency: instruction reaches if_load in the same cycle as its mem_ready when no stall is present. Zero-wait memory gives one instruction per cycle.

Test Plan:
- Reset: hold rst=0 with mem_ready=1 -> mem_req=0, all outputs 0. Release rst -> cycle 1: mem_req=0; cycle 2: mem_req=1, mem_addr=0.
- Zero-wait streaming: mem_ready=1 constantly, mem_rdata=addr^32'hA5A5A5A5 -> if_load every cycle with if_pc=4,8,12,…; if_instr matches each address.
- Stall buffering: stall_in=1 when fetch of 0x10 completes -> HOLD, mem_req=0. stall_in=0 after 3 cycles -> if_load=1, if_pc=0x14, buffered instr, then mem_addr=0x14.
- Branch mid-wait: mem latency 4; branch_taken with target 0x200 in wait cycle 2 -> if_flush pulse; mem_addr held until ready; response discarded (if_load=0); next mem_addr=0x200.
- Branch vs stall, and branch during HOLD: simultaneous branch_taken=1 and stall_in=1 on a response -> data dropped, next mem_addr=target. Branch in HOLD -> buffer dropped, mem_addr=target.
- Watchdog, wrap, and reset mid-transaction:
  - mem_ready low for MAX_WAIT cycles -> mem_err=1 and stays 1 after the transaction completes.
  - Fetch at 0xFFFF_FFFC -> next mem_addr=0.
  - rst=0 mid-REQ -> mem_req=0 asynchronously.
